// File: rtl/pwm_pkg.sv
// Shared definitions for the breathing-PWM controller: phase encoding,
// default period width and the full-duty compare helper.
package pwm_pkg;

  localparam int DEFAULT_TOP_WIDTH = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_RAMP_UP   = 3'd2;
  localparam logic [2:0] ST_HOLD_HIGH = 3'd3;
  localparam logic [2:0] ST_RAMP_DOWN = 3'd4;
  localparam logic [2:0] ST_HOLD_LOW  = 3'd5;

  // A compare of top+1 keeps the output high for the whole period.
  function automatic logic [31:0] max_compare(input logic [31:0] top);
    return top + 32'd1;
  endfunction

endpackage

// File: rtl/pwm_event_counter.sv
// Counts qualified pulses and flags the pulse that reaches the terminal
// count, wrapping back to zero on that same pulse.
module pwm_event_counter #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic pulse,
  output logic done
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count;

  assign done = pulse && (count == LAST);

  // Advance on each qualified pulse, restarting after the terminal one.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (pulse) begin
      count <= done ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_breathe_ctrl.sv
// Breathing-fade controller for the pwm block: loads the period once per
// run, then ramps the compare value up, holds, ramps down, holds, repeat.
// Compare changes only land on pwm cycle boundaries.
module pwm_breathe_ctrl
  import pwm_pkg::*;
#(
  parameter int TOP_WIDTH   = DEFAULT_TOP_WIDTH,
  parameter int DIVIDE      = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_enable,
  input  logic [TOP_WIDTH-1:0] i_top,
  input  logic [TOP_WIDTH-1:0] i_step,
  input  logic                 i_cycle_end,
  output logic [TOP_WIDTH-1:0] o_top,
  output logic                 o_top_valid,
  output logic [TOP_WIDTH:0]   o_compare,
  output logic                 o_compare_valid,
  output logic [2:0]           o_phase
);

  localparam int CW = TOP_WIDTH + 1;
  localparam int AW = TOP_WIDTH + 2;

  logic [2:0]    state;
  logic [AW-1:0] max_ext;
  logic [AW-1:0] step_ext;
  logic [AW-1:0] cmp_ext;
  logic [AW-1:0] up_sum;
  logic [AW-1:0] next_up;
  logic [AW-1:0] next_down;
  logic          in_ramp;
  logic          in_hold;
  logic          running;
  logic          disable_now;
  logic          div_done;
  logic          hold_done;

  assign o_phase = state;

  // Compare arithmetic carries an extra bit so up-steps cannot wrap
  // before the saturation check.
  assign max_ext   = AW'(max_compare(32'(o_top)));
  assign step_ext  = (i_step == '0) ? AW'(1) : AW'(i_step);
  assign cmp_ext   = AW'(o_compare);
  assign up_sum    = cmp_ext + step_ext;
  assign next_up   = (up_sum >= max_ext) ? max_ext : up_sum;
  assign next_down = (cmp_ext <= step_ext) ? '0 : cmp_ext - step_ext;

  assign in_ramp     = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);
  assign in_hold     = (state == ST_HOLD_HIGH) || (state == ST_HOLD_LOW);
  assign running     = (state != ST_IDLE) && (state != ST_LOAD);
  assign disable_now = running && i_cycle_end && !i_enable;

  pwm_event_counter #(
    .WIDTH    (8),
    .TERMINAL (DIVIDE)
  ) u_divide_counter (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (state == ST_LOAD),
    .pulse (in_ramp && i_cycle_end && i_enable),
    .done  (div_done)
  );

  pwm_event_counter #(
    .WIDTH    (16),
    .TERMINAL (HOLD_CYCLES)
  ) u_hold_counter (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (state == ST_LOAD),
    .pulse (in_hold && i_cycle_end && i_enable),
    .done  (hold_done)
  );

  // Phase sequencing and compare updates; a pending disable beats any step
  // that falls on the same cycle boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= ST_IDLE;
      o_top           <= '0;
      o_top_valid     <= 1'b0;
      o_compare       <= '0;
      o_compare_valid <= 1'b0;
    end else begin
      o_top_valid     <= 1'b0;
      o_compare_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_compare <= '0;
          if (i_enable) begin
            o_top           <= i_top;
            o_top_valid     <= 1'b1;
            o_compare_valid <= 1'b1;
            state           <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state <= ST_RAMP_UP;
        end
        default: begin
          if (disable_now) begin
            o_compare       <= '0;
            o_compare_valid <= 1'b1;
            state           <= ST_IDLE;
          end else begin
            case (state)
              ST_RAMP_UP: begin
                if (div_done) begin
                  o_compare       <= CW'(next_up);
                  o_compare_valid <= 1'b1;
                  if (next_up == max_ext) state <= ST_HOLD_HIGH;
                end
              end
              ST_HOLD_HIGH: begin
                if (hold_done) state <= ST_RAMP_DOWN;
              end
              ST_RAMP_DOWN: begin
                if (div_done) begin
                  o_compare       <= CW'(next_down);
                  o_compare_valid <= 1'b1;
                  if (next_down == '0) state <= ST_HOLD_LOW;
                end
              end
              ST_HOLD_LOW: begin
                if (hold_done) state <= ST_RAMP_UP;
              end
              default: begin
                state <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_breathe_ctrl.sv
// Bench for pwm_breathe_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against an event-counting reference model.
module tb_pwm_breathe_ctrl;

  localparam int TW   = 8;
  localparam int DIV  = 2;
  localparam int HOLD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [TW-1:0] top;
  logic [TW-1:0] step;
  logic          cycle_end;
  logic [TW-1:0] o_top;
  logic          o_top_valid;
  logic [TW:0]   o_compare;
  logic          o_compare_valid;
  logic [2:0]    o_phase;

  int compare_count  = 0;
  int mismatch_count = 0;

  // Reference model: phase number, latched period, compare level and the
  // count of cycle_end events seen since the current phase began.
  int m_phase = 0;
  int m_top   = 0;
  int m_cmp   = 0;
  int m_ev    = 0;
  int m_tv    = 0;
  int m_cv    = 0;

  int ce_tick = 0;

  pwm_breathe_ctrl #(
    .TOP_WIDTH   (TW),
    .DIVIDE      (DIV),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_top           (top),
    .i_step          (step),
    .i_cycle_end     (cycle_end),
    .o_top           (o_top),
    .o_top_valid     (o_top_valid),
    .o_compare       (o_compare),
    .o_compare_valid (o_compare_valid),
    .o_phase         (o_phase)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compare_count++;
    if (observed != expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  // Advance the model by one clock using the inputs the DUT saw at that edge.
  task automatic modelStep(input bit r, input bit en, input bit ce, input int t, input int s);
    int mx;
    int st;
    m_tv = 0;
    m_cv = 0;
    if (r) begin
      m_phase = 0; m_top = 0; m_cmp = 0; m_ev = 0;
      return;
    end
    mx = m_top + 1;
    st = (s == 0) ? 1 : s;
    if (m_phase == 0) begin
      m_cmp = 0;
      if (en) begin
        m_top = t; m_phase = 1; m_tv = 1; m_cv = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2; m_ev = 0;
    end else if (ce) begin
      if (!en) begin
        m_cmp = 0; m_cv = 1; m_phase = 0;
      end else begin
        m_ev++;
        if (m_phase == 2 && m_ev == DIV) begin
          m_ev = 0; m_cv = 1;
          m_cmp = (m_cmp + st > mx) ? mx : m_cmp + st;
          if (m_cmp == mx) m_phase = 3;
        end else if (m_phase == 4 && m_ev == DIV) begin
          m_ev = 0; m_cv = 1;
          m_cmp = (m_cmp - st < 0) ? 0 : m_cmp - st;
          if (m_cmp == 0) m_phase = 5;
        end else if (m_phase == 3 && m_ev == HOLD) begin
          m_ev = 0; m_phase = 4;
        end else if (m_phase == 5 && m_ev == HOLD) begin
          m_ev = 0; m_phase = 2;
        end
      end
    end
  endtask

  // Drive one clock of inputs, update the model and compare all outputs.
  task automatic applyStimulus(input bit r, input bit en, input bit ce, input int t, input int s);
    @(negedge clk);
    rst       = r;
    enable    = en;
    cycle_end = ce;
    top       = TW'(t);
    step      = TW'(s);
    @(posedge clk);
    modelStep(r, en, ce, t, s);
    #1;
    checkOutput("phase",         int'(o_phase),         m_phase);
    checkOutput("top",           int'(o_top),           m_top);
    checkOutput("top_valid",     int'(o_top_valid),     m_tv);
    checkOutput("compare",       int'(o_compare),       m_cmp);
    checkOutput("compare_valid", int'(o_compare_valid), m_cv);
  endtask

  // One cycle with a cycle_end pulse on every fourth clock.
  task automatic tick(input bit r, input bit en, input int t, input int s);
    ce_tick = (ce_tick + 1) % 4;
    applyStimulus(r, en, (ce_tick == 0), t, s);
  endtask

  task automatic resetCycles(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b1, 3, 1);
  endtask

  initial begin
    int guard;
    int r_top;
    int r_step;
    bit r_en;
    rst = 1'b1; enable = 1'b0; cycle_end = 1'b0; top = '0; step = '0;

    $display("[TB] reset and load, top=3 step=1");
    resetCycles(3);
    for (int i = 0; i < 160; i++) tick(1'b0, 1'b1, 3, 1);

    $display("[TB] saturation, top=3 step=3");
    resetCycles(2);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 3, 3);

    $display("[TB] step zero");
    resetCycles(2);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 3, 0);

    $display("[TB] disable at compare=2 in ramp up");
    resetCycles(2);
    guard = 0;
    while (!(m_phase == 2 && m_cmp == 2) && guard < 200) begin
      tick(1'b0, 1'b1, 3, 1);
      guard++;
    end
    checkOutput("reach_cmp2_timeout", guard < 200 ? 1 : 0, 1);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 3, 1);
    checkOutput("idle_after_disable", int'(o_phase), 0);

    $display("[TB] disable cancelled before cycle_end");
    guard = 0;
    while (!(m_phase == 2 && m_cmp == 2) && guard < 200) begin
      tick(1'b0, 1'b1, 3, 1);
      guard++;
    end
    checkOutput("reach_cmp2_again_timeout", guard < 200 ? 1 : 0, 1);
    while (ce_tick != 1) tick(1'b0, 1'b1, 3, 1);
    tick(1'b0, 1'b0, 3, 1);
    tick(1'b0, 1'b1, 3, 1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 3, 1);

    $display("[TB] top change during hold high, then reset in ramp down");
    guard = 0;
    while (m_phase != 3 && guard < 300) begin
      tick(1'b0, 1'b1, 3, 1);
      guard++;
    end
    checkOutput("reach_hold_high_timeout", guard < 300 ? 1 : 0, 1);
    guard = 0;
    while (m_phase != 4 && guard < 300) begin
      tick(1'b0, 1'b1, 10, 1);
      guard++;
    end
    checkOutput("reach_ramp_down_timeout", guard < 300 ? 1 : 0, 1);
    checkOutput("top_kept", int'(o_top), 3);
    tick(1'b0, 1'b1, 10, 1);
    tick(1'b1, 1'b1, 10, 1);
    checkOutput("reset_compare", int'(o_compare), 0);

    $display("[TB] randomized traffic");
    r_top = 3; r_step = 1; r_en = 1'b1;
    for (int i = 0; i < 8000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        r_top  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 12));
        r_step = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 39) == 0) r_en = ~r_en;
      if ($urandom_range(0, 599) == 0)
        applyStimulus(1'b1, r_en, 1'b0, r_top, r_step);
      else
        applyStimulus(1'b0, r_en, ($urandom_range(0, 2) == 0), r_top, r_step);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule

// File: doc/pwm_breathe_ctrl.md
Name: pwm_breathe_ctrl

Overview:
- Controller that drives the `pwm` block's configuration inputs to produce a "breathing" fade: ramp up, hold high, ramp down, hold low, repeat.
- Replaces the static `pwm_sequencer` in the PWM top level.
- Loads the period (top) once per run.
- Steps the duty-cycle compare value only on PWM cycle boundaries, using the `pwm` block's `o_cycle_end`, so no period is ever glitched.

Parameters:
- TOP_WIDTH, 8, width of the period register; compare is TOP_WIDTH+1 bits.
- DIVIDE, 4, number of PWM cycle_end pulses per ramp step; legal range 1..255.
- HOLD_CYCLES, 64, number of cycle_end pulses spent in each hold state; legal range 1..65535.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  level; 1 = run the fade, 0 = go idle.
- i_top  in  TOP_WIDTH  requested PWM period; sampled only on IDLE exit.
- i_step  in  TOP_WIDTH  compare increment/decrement per step; 0 is treated as 1.
- i_cycle_end  in  1  1-cycle pulse from `pwm` `o_cycle_end`.
- o_top  out  TOP_WIDTH  period sent to `pwm`.
- o_top_valid  out  1  1-cycle load strobe for o_top.
- o_compare  out  TOP_WIDTH+1  compare value sent to `pwm`.
- o_compare_valid  out  1  1-cycle load strobe for o_compare.
- o_phase  out  3  current state encoding, for debug/LED.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE; o_top=0; o_top_valid=0; o_compare=0; o_compare_valid=0; o_phase=0; all counters 0.
- Arithmetic:
  - MAX = latched top + 1, computed at TOP_WIDTH+1 bits. A compare of MAX means 100% duty.
  - All compare arithmetic is TOP_WIDTH+2 bits internally.
  - Up-steps saturate at MAX; down-steps saturate at 0.
- States and o_phase encoding: IDLE=0, LOAD=1, RAMP_UP=2, HOLD_HIGH=3, RAMP_DOWN=4, HOLD_LOW=5.
- IDLE:
  - o_compare is held at 0.
  - If i_enable=1: latch i_top into o_top and go to LOAD.
- LOAD (exactly 1 cycle):
  - Pulse o_top_valid=1 and o_compare_valid=1 with o_compare=0.
  - Clear the divide counter and the hold counter.
  - Go to RAMP_UP.
- Event counting: in RAMP/HOLD states, only i_cycle_end pulses advance counters; other cycles hold state.
- RAMP_UP:
  - On every DIVIDE-th cycle_end, compare += step (saturating), and o_compare_valid pulses on the following cycle. Update latency is 1 cycle after the triggering cycle_end.
  - When the new compare equals MAX, go to HOLD_HIGH.
- HOLD_HIGH: after HOLD_CYCLES cycle_end pulses, go to RAMP_DOWN. No compare strobe.
- RAMP_DOWN: mirror of RAMP_UP (compare -= step); on reaching 0, go to HOLD_LOW.
- HOLD_LOW: after HOLD_CYCLES cycle_end pulses, go to RAMP_UP.
- Disable:
  - i_enable=0 in any non-IDLE state takes effect at the next i_cycle_end.
  - On that edge: o_compare=0 with an o_compare_valid pulse, then go to IDLE.
  - i_enable re-asserted before that cycle_end cancels the disable.
- Simultaneous events:
  - i_enable falling together with a step-due cycle_end: the disable wins and compare goes to 0.
  - i_cycle_end during LOAD is ignored.
- Reconfiguration: changes to i_top after LOAD are ignored until the next IDLE→LOAD. i_step is sampled at each step.
- Strobes: o_top_valid and o_compare_valid are never high for 2 consecutive cycles from the same event.
- Reset mid-operation: return to reset values next cycle; no strobe issued.

Decomposition:
- Package `pwm_pkg`: state encoding constants (IDLE..HOLD_LOW), default TOP_WIDTH, and the MAX computation helper.
- One natural sub-module, `pwm_event_counter`: a counter that counts qualified pulses and emits a done strobe at a terminal count.
  - Instance 1: DIVIDE counter.
  - Instance 2: HOLD_CYCLES counter.
- The FSM and compare datapath stay in pwm_breathe_ctrl.

Test Plan:
- Reset/load:
  - Stimulus: assert i_rst, then deassert with i_enable=1, i_top=3.
  - Required: all outputs 0 during reset; one cycle with o_top=3, o_top_valid=1, o_compare_valid=1, o_compare=0; o_phase goes 0→1→2.
- Ramp stepping:
  - Stimulus: DIVIDE=2, HOLD_CYCLES=2, top=3, step=1; a cycle_end pulse every 4 clocks.
  - Required: compare strobes 1,2,3,4, each 1 cycle after every 2nd cycle_end; then HOLD_HIGH.
  - Then, after 2 cycle_ends: ramp down 3,2,1,0; then HOLD_LOW; then RAMP_UP again.
- Saturation:
  - Stimulus: top=3, step=3.
  - Required: up sequence 3,4 (clamped at MAX=4); down sequence 1,0 (clamped at 0); no wrap at any point.
- Step zero:
  - Stimulus: step=0.
  - Required: behaves exactly like step=1.
- Disable timing:
  - Stimulus: drop i_enable mid-RAMP_UP at compare=2.
  - Required: no change until the next cycle_end, then o_compare=0 with a strobe; IDLE after.
  - Stimulus: re-raise i_enable before that cycle_end.
  - Required: ramp continues unchanged.
- Mid-run reconfiguration and reset:
  - Stimulus: change i_top to 10 during HOLD_HIGH.
  - Required: o_top stays 3 and no o_top_valid pulse.
  - Stimulus: assert i_rst in RAMP_DOWN.
  - Required: all outputs 0 on the next cycle, with no strobe.
